// File: rtl/leg_decode_stage_if.sv
// -----------------------------------------------------------------------------
// leg_decode_stage_if
// Handshake bundle between instruction fetch, the LEG decode stage and the
// ALU/shift execute unit.
//   in_*  : fetch -> decode instruction (valid/ready, opcode, arg1, arg2, dest)
//   out_* : decode -> execute micro-op (valid/ready, flags, func, operands,
//           first/last markers)
// Modports:
//   master : environment side (drives instructions, accepts micro-ops)
//   slave  : decode stage side
// -----------------------------------------------------------------------------
interface leg_decode_stage_if #(
    parameter int DATA_W = 8
);
    // Instruction side
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_opcode;
    logic [DATA_W-1:0] in_arg1;
    logic [DATA_W-1:0] in_arg2;
    logic [DATA_W-1:0] in_dest;

    // Micro-op side
    logic              out_valid;
    logic              out_ready;
    logic              out_imm_a;
    logic              out_imm_b;
    logic              out_imm_all;
    logic              out_lsl;
    logic              out_lsr;
    logic              out_cond;
    logic              out_illegal;
    logic [3:0]        out_func;
    logic [DATA_W-1:0] out_arg1;
    logic [DATA_W-1:0] out_arg2;
    logic [DATA_W-1:0] out_dest;
    logic              out_first;
    logic              out_last;

    modport master (
        output in_valid, in_opcode, in_arg1, in_arg2, in_dest, out_ready,
        input  in_ready, out_valid, out_imm_a, out_imm_b, out_imm_all,
               out_lsl, out_lsr, out_cond, out_illegal, out_func,
               out_arg1, out_arg2, out_dest, out_first, out_last
    );

    modport slave (
        input  in_valid, in_opcode, in_arg1, in_arg2, in_dest, out_ready,
        output in_ready, out_valid, out_imm_a, out_imm_b, out_imm_all,
               out_lsl, out_lsr, out_cond, out_illegal, out_func,
               out_arg1, out_arg2, out_dest, out_first, out_last
    );
endinterface

// File: rtl/leg_decode_stage.sv
// -----------------------------------------------------------------------------
// leg_decode_stage
// Registered opcode decode stage for the LEG core. Accepts one instruction per
// valid/ready handshake and emits a registered micro-op. With SERIAL_SHIFT=1
// an immediate LSL/LSR by A (A >= 2) is expanded into A one-bit shift micro-ops
// so execute only needs a 1-bit shifter.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : leg_decode_stage_if.slave (instruction in, micro-op out)
// -----------------------------------------------------------------------------
module leg_decode_stage #(
    parameter int DATA_W       = 8,
    parameter bit SERIAL_SHIFT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    leg_decode_stage_if.slave   bus
);
    localparam int AW = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SERIAL = 2'd2
    } state_t;

    typedef struct packed {
        logic              imm_a;
        logic              imm_b;
        logic              imm_all;
        logic              lsl;
        logic              lsr;
        logic              cond;
        logic              illegal;
        logic [3:0]        func;
        logic [DATA_W-1:0] arg1;
        logic [DATA_W-1:0] arg2;
        logic [DATA_W-1:0] dest;
        logic              first;
        logic              last;
    } uop_t;

    state_t         state_q, state_d;
    logic [AW:0]    remaining_q, remaining_d;
    logic           valid_q, valid_d;
    uop_t           uop_q, uop_d;

    uop_t              dec_uop;
    logic              dec_expand;
    logic              dec_multi;
    logic [DATA_W-1:0] amt_masked;
    logic [AW-1:0]     dec_amt;
    logic              accept;

    // Shift amount = arg2 & (DATA_W-1): only the low log2(DATA_W) bits survive.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_amt_mask
        if (gi < AW) begin : g_keep
            assign amt_masked[gi] = bus.in_arg2[gi];
        end else begin : g_drop
            assign amt_masked[gi] = 1'b0;
        end
    end
    assign dec_amt = amt_masked[AW-1:0];

    // Instruction decode (purely combinational on the input fields)
    always_comb begin
        logic       c;
        logic [3:0] f;
        dec_uop    = '0;
        c          = bus.in_opcode[5];
        f          = bus.in_opcode[3:0];
        dec_uop.imm_a   = bus.in_opcode[7] | ((f == 4'd9) & ~c);
        dec_uop.imm_b   = bus.in_opcode[6] | (((f == 4'd7) | (f == 4'd9)) & ~c);
        dec_uop.imm_all = (bus.in_opcode[7] & bus.in_opcode[6]) | ((f == 4'd9) & ~c);
        dec_uop.lsl     = (f == 4'd10) & ~c;
        dec_uop.lsr     = (f == 4'd13) & ~c;
        dec_uop.cond    = c;
        dec_uop.illegal = bus.in_opcode[4];
        dec_uop.func    = f;
        dec_uop.arg1    = bus.in_arg1;
        dec_uop.dest    = bus.in_dest;

        // Only immediate-amount shifts are serialised; register amounts pass whole.
        dec_expand = SERIAL_SHIFT & (dec_uop.lsl | dec_uop.lsr) & bus.in_opcode[6];
        dec_multi  = dec_expand & (dec_amt >= AW'(2));

        if (dec_multi) begin
            dec_uop.arg2 = {{(DATA_W-1){1'b0}}, 1'b1};
        end else if (dec_expand) begin
            dec_uop.arg2 = amt_masked;
        end else begin
            dec_uop.arg2 = bus.in_arg2;
        end
        dec_uop.first = 1'b1;
        dec_uop.last  = ~dec_multi;
    end

    assign bus.in_ready = ~rst & ((state_q == IDLE) | ((state_q == HOLD) & bus.out_ready));
    assign accept       = bus.in_valid & bus.in_ready;

    // Next-state / datapath
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        valid_d     = valid_q;
        uop_d       = uop_q;

        case (state_q)
            IDLE, HOLD: begin
                // Held micro-op retires; a same-cycle accept below overrides.
                if ((state_q == HOLD) && bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
                if (accept) begin
                    uop_d   = dec_uop;
                    valid_d = 1'b1;
                    if (dec_multi) begin
                        state_d     = SERIAL;
                        remaining_d = {1'b0, dec_amt} - {{AW{1'b0}}, 1'b1};
                    end else begin
                        state_d     = HOLD;
                        remaining_d = '0;
                    end
                end
            end
            SERIAL: begin
                if (bus.out_ready) begin
                    remaining_d = remaining_q - {{AW{1'b0}}, 1'b1};
                    uop_d.first = 1'b0;
                    // Retiring the second-to-last step: the next one is final.
                    if (remaining_q == {{AW{1'b0}}, 1'b1}) begin
                        uop_d.last = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                valid_d     = 1'b0;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            uop_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            valid_q     <= valid_d;
            uop_q       <= uop_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_imm_a   = uop_q.imm_a;
    assign bus.out_imm_b   = uop_q.imm_b;
    assign bus.out_imm_all = uop_q.imm_all;
    assign bus.out_lsl     = uop_q.lsl;
    assign bus.out_lsr     = uop_q.lsr;
    assign bus.out_cond    = uop_q.cond;
    assign bus.out_illegal = uop_q.illegal;
    assign bus.out_func    = uop_q.func;
    assign bus.out_arg1    = uop_q.arg1;
    assign bus.out_arg2    = uop_q.arg2;
    assign bus.out_dest    = uop_q.dest;
    assign bus.out_first   = uop_q.first;
    assign bus.out_last    = uop_q.last;

endmodule

// File: tb/tb_leg_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_leg_decode_stage
// Scoreboard bench for leg_decode_stage (DATA_W=8, SERIAL_SHIFT=1). Expected
// micro-ops are pushed from a reference model when an instruction is accepted;
// observed micro-ops are collected on each retire and compared per scenario.
// -----------------------------------------------------------------------------
module tb_leg_decode_stage;
    localparam int DW  = 8;
    localparam bit SER = 1'b1;

    typedef struct packed {
        logic [7:0]    op;
        logic [DW-1:0] a1;
        logic [DW-1:0] a2;
        logic [DW-1:0] d;
    } instr_t;

    typedef struct packed {
        logic          imm_a;
        logic          imm_b;
        logic          imm_all;
        logic          lsl;
        logic          lsr;
        logic          cond;
        logic          illegal;
        logic [3:0]    func;
        logic [DW-1:0] arg1;
        logic [DW-1:0] arg2;
        logic [DW-1:0] dest;
        logic          first;
        logic          last;
    } uop_t;

    logic clk;
    logic rst;

    leg_decode_stage_if #(.DATA_W(DW)) bus ();

    leg_decode_stage #(.DATA_W(DW), .SERIAL_SHIFT(SER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_cmp;
    int     n_fail;
    instr_t instr_q[$];
    uop_t   exp_q[$];
    uop_t   obs_q[$];
    logic [15:0] rdy_pat;
    int     rdy_len;
    int     irdy_low;
    int     stall_viol;
    int     timed_out;
    int     first_valid_cyc;
    int     last_cyc;

    function automatic uop_t got_uop();
        uop_t u;
        u.imm_a   = bus.out_imm_a;
        u.imm_b   = bus.out_imm_b;
        u.imm_all = bus.out_imm_all;
        u.lsl     = bus.out_lsl;
        u.lsr     = bus.out_lsr;
        u.cond    = bus.out_cond;
        u.illegal = bus.out_illegal;
        u.func    = bus.out_func;
        u.arg1    = bus.out_arg1;
        u.arg2    = bus.out_arg2;
        u.dest    = bus.out_dest;
        u.first   = bus.out_first;
        u.last    = bus.out_last;
        return u;
    endfunction

    // Reference model: expand one accepted instruction into expected micro-ops.
    task automatic model_push(input instr_t in);
        uop_t       u;
        logic       c;
        logic [3:0] f;
        logic       ex;
        int         a;
        u  = '0;
        c  = in.op[5];
        f  = in.op[3:0];
        u.imm_a   = in.op[7] | (f == 4'd9 && !c);
        u.imm_b   = in.op[6] | ((f == 4'd7 || f == 4'd9) && !c);
        u.imm_all = (in.op[7] & in.op[6]) | (f == 4'd9 && !c);
        u.lsl     = (f == 4'd10 && !c);
        u.lsr     = (f == 4'd13 && !c);
        u.cond    = c;
        u.illegal = in.op[4];
        u.func    = f;
        u.arg1    = in.a1;
        u.dest    = in.d;
        ex = SER && (u.lsl || u.lsr) && in.op[6];
        a  = int'(in.a2) & (DW - 1);
        if (ex && a >= 2) begin
            for (int k = 0; k < a; k++) begin
                u.arg2  = DW'(1);
                u.first = (k == 0);
                u.last  = (k == a - 1);
                exp_q.push_back(u);
            end
        end else begin
            u.arg2  = ex ? DW'(a) : in.a2;
            u.first = 1'b1;
            u.last  = 1'b1;
            exp_q.push_back(u);
        end
    endtask

    task automatic clear_sb();
        instr_q.delete();
        exp_q.delete();
        obs_q.delete();
    endtask

    // Drives instr_q in order with the out_ready pattern, collecting retires.
    task automatic run_stream(input int budget);
        int   idx;
        int   cyc;
        logic acc;
        logic prev_stall;
        uop_t prev;
        idx = 0; cyc = 0; prev = '0; prev_stall = 1'b0;
        irdy_low = 0; stall_viol = 0; timed_out = 0;
        first_valid_cyc = -1; last_cyc = -1;
        forever begin
            @(negedge clk);
            if (idx < instr_q.size()) begin
                bus.in_valid  = 1'b1;
                bus.in_opcode = instr_q[idx].op;
                bus.in_arg1   = instr_q[idx].a1;
                bus.in_arg2   = instr_q[idx].a2;
                bus.in_dest   = instr_q[idx].d;
            end else begin
                bus.in_valid  = 1'b0;
            end
            bus.out_ready = rdy_pat[cyc % rdy_len];
            #1;
            if (prev_stall && (!bus.out_valid || got_uop() !== prev)) stall_viol++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev       = got_uop();
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_valid && bus.out_ready) obs_q.push_back(got_uop());
            acc = bus.in_valid && bus.in_ready;
            if (bus.in_valid && !bus.in_ready) irdy_low++;
            if (acc) begin
                model_push(instr_q[idx]);
                idx++;
            end
            if (idx == instr_q.size() && !acc && !bus.out_valid) begin
                last_cyc = cyc;
                break;
            end
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_opcode = 8'hC0; bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_cmp++;
        if (got_uop() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", got_uop());
        end
        rst = 1'b0; bus.in_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready);
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        clear_sb();
        rdy_pat = 16'h1; rdy_len = 1;
        instr_q.push_back('{op: 8'hC0, a1: 8'd3, a2: 8'd4, d: 8'd2});
        run_stream(50);
        n_cmp++;
        if (timed_out !== 0) begin n_fail++; $display("FAIL basic_timeout: got %0d expected 0", timed_out); end
        n_cmp++;
        if (first_valid_cyc !== 1) begin n_fail++; $display("FAIL basic_latency: got %0d expected 1", first_valid_cyc); end
        n_cmp++;
        if (obs_q.size() !== 1) begin
            n_fail++; $display("FAIL basic_count: got %0d expected 1", obs_q.size());
        end else begin
            n_cmp++;
            if (!(obs_q[0].imm_a && obs_q[0].imm_b && obs_q[0].imm_all && obs_q[0].first
                  && obs_q[0].last && obs_q[0].arg2 == 8'd4 && obs_q[0].arg1 == 8'd3)) begin
                n_fail++; $display("FAIL basic_fields: got %h expected imm flags/first/last set arg1=3 arg2=4", obs_q[0]);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_uop%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        $display("test_basic: %0d micro-ops", obs_q.size());
    endtask

    task automatic test_back_to_back();
        clear_sb();
        rdy_pat = 16'h1; rdy_len = 1;
        instr_q.push_back('{op: 8'h0A, a1: 8'h81, a2: 8'h0B, d: 8'd1});
        instr_q.push_back('{op: 8'h09, a1: 8'h12, a2: 8'h34, d: 8'd7});
        run_stream(50);
        n_cmp++;
        if (timed_out !== 0) begin n_fail++; $display("FAIL b2b_timeout: got %0d expected 0", timed_out); end
        n_cmp++;
        if (irdy_low !== 0) begin n_fail++; $display("FAIL b2b_in_ready: got %0d low cycles expected 0", irdy_low); end
        n_cmp++;
        if (last_cyc !== 3) begin n_fail++; $display("FAIL b2b_cycles: got %0d expected 3", last_cyc); end
        n_cmp++;
        if (obs_q.size() !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 2", obs_q.size());
        end else begin
            n_cmp++;
            if (!(obs_q[0].lsl && obs_q[0].arg2 == 8'h0B && obs_q[1].imm_all && !obs_q[1].lsl)) begin
                n_fail++; $display("FAIL b2b_flags: got %h %h expected lsl then imm_all", obs_q[0], obs_q[1]);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_uop%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        $display("test_back_to_back: %0d micro-ops", obs_q.size());
    endtask

    task automatic test_serial();
        clear_sb();
        rdy_pat = 16'h1; rdy_len = 1;
        instr_q.push_back('{op: 8'h4D, a1: 8'hA5, a2: 8'd5, d: 8'd3});
        instr_q.push_back('{op: 8'h01, a1: 8'h11, a2: 8'h22, d: 8'd4});
        run_stream(100);
        n_cmp++;
        if (timed_out !== 0) begin n_fail++; $display("FAIL serial_timeout: got %0d expected 0", timed_out); end
        n_cmp++;
        if (irdy_low !== 4) begin n_fail++; $display("FAIL serial_in_ready_low: got %0d expected 4", irdy_low); end
        n_cmp++;
        if (last_cyc !== 7) begin n_fail++; $display("FAIL serial_cycles: got %0d expected 7", last_cyc); end
        n_cmp++;
        if (obs_q.size() !== 6) begin
            n_fail++; $display("FAIL serial_count: got %0d expected 6", obs_q.size());
        end else begin
            n_cmp++;
            if (!(obs_q[0].first && !obs_q[0].last && !obs_q[3].first && !obs_q[3].last
                  && obs_q[4].last && !obs_q[4].first && obs_q[2].arg2 == 8'd1 && obs_q[2].lsr)) begin
                n_fail++; $display("FAIL serial_markers: got %h %h %h expected first on #1 last on #5", obs_q[0], obs_q[3], obs_q[4]);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL serial_uop%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        $display("test_serial: %0d micro-ops", obs_q.size());
    endtask

    task automatic test_stall();
        clear_sb();
        rdy_pat = 16'b1001; rdy_len = 4;
        instr_q.push_back('{op: 8'h4D, a1: 8'h5A, a2: 8'd5, d: 8'd6});
        run_stream(200);
        n_cmp++;
        if (timed_out !== 0) begin n_fail++; $display("FAIL stall_timeout: got %0d expected 0", timed_out); end
        n_cmp++;
        if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", stall_viol); end
        n_cmp++;
        if (obs_q.size() !== 5) begin n_fail++; $display("FAIL stall_count: got %0d expected 5", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_uop%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        $display("test_stall: %0d micro-ops", obs_q.size());
    endtask

    task automatic test_cond_and_small();
        clear_sb();
        rdy_pat = 16'h1; rdy_len = 1;
        instr_q.push_back('{op: 8'h2A, a1: 8'h40, a2: 8'd3, d: 8'd1});
        instr_q.push_back('{op: 8'h4A, a1: 8'h41, a2: 8'h09, d: 8'd2});
        instr_q.push_back('{op: 8'h13, a1: 8'h42, a2: 8'h07, d: 8'd3});
        run_stream(50);
        n_cmp++;
        if (timed_out !== 0) begin n_fail++; $display("FAIL cond_timeout: got %0d expected 0", timed_out); end
        n_cmp++;
        if (obs_q.size() !== 3) begin
            n_fail++; $display("FAIL cond_count: got %0d expected 3", obs_q.size());
        end else begin
            n_cmp++;
            if (!(!obs_q[0].lsl && obs_q[0].cond && obs_q[1].lsl && obs_q[1].arg2 == 8'd1
                  && obs_q[1].first && obs_q[1].last && obs_q[2].illegal)) begin
                n_fail++; $display("FAIL cond_fields: got %h %h %h expected cond/A=1/illegal", obs_q[0], obs_q[1], obs_q[2]);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL cond_uop%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        $display("test_cond_and_small: %0d micro-ops", obs_q.size());
    endtask

    task automatic test_max_amount();
        clear_sb();
        rdy_pat = 16'h1; rdy_len = 1;
        instr_q.push_back('{op: 8'h4A, a1: 8'h01, a2: 8'h07, d: 8'd1});
        instr_q.push_back('{op: 8'h4D, a1: 8'h02, a2: 8'hFF, d: 8'd2});
        instr_q.push_back('{op: 8'h4A, a1: 8'h03, a2: 8'h10, d: 8'd3});
        instr_q.push_back('{op: 8'h0A, a1: 8'h04, a2: 8'hFF, d: 8'd4});
        run_stream(200);
        n_cmp++;
        if (timed_out !== 0) begin n_fail++; $display("FAIL max_timeout: got %0d expected 0", timed_out); end
        n_cmp++;
        if (obs_q.size() !== 16) begin
            n_fail++; $display("FAIL max_count: got %0d expected 16", obs_q.size());
        end else begin
            n_cmp++;
            if (!(obs_q[6].last && obs_q[7].first && obs_q[13].last && obs_q[14].arg2 == 8'h00
                  && obs_q[15].arg2 == 8'hFF)) begin
                n_fail++; $display("FAIL max_fields: got %h %h %h expected 7+7 steps, arg2 0 then FF", obs_q[6], obs_q[14], obs_q[15]);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL max_uop%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        $display("test_max_amount: %0d micro-ops", obs_q.size());
    endtask

    task automatic test_reset_mid_expansion();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_opcode = 8'h4A; bus.in_arg1 = 8'h21;
        bus.in_arg2 = 8'd6; bus.in_dest = 8'd5; bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept: got %b expected 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_cmp++;
        if (!(bus.out_valid === 1'b1 && bus.out_first === 1'b1 && bus.out_arg2 === 8'd1)) begin
            n_fail++; $display("FAIL rstmid_step1: got v=%b first=%b arg2=%h expected 1 1 01", bus.out_valid, bus.out_first, bus.out_arg2);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (!(bus.out_valid === 1'b1 && bus.out_first === 1'b0 && bus.out_last === 1'b0)) begin
            n_fail++; $display("FAIL rstmid_step2: got v=%b first=%b last=%b expected 1 0 0", bus.out_valid, bus.out_first, bus.out_last);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || got_uop() !== '0) begin
            n_fail++; $display("FAIL rstmid_cleared: got v=%b uop=%h expected 0", bus.out_valid, got_uop());
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_more: got %b expected 0", bus.out_valid); end
        clear_sb();
        rdy_pat = 16'h1; rdy_len = 1;
        instr_q.push_back('{op: 8'h87, a1: 8'h99, a2: 8'h66, d: 8'd9});
        run_stream(50);
        n_cmp++;
        if (obs_q.size() !== 1 || timed_out !== 0) begin
            n_fail++; $display("FAIL rstmid_fresh_count: got %0d (timeout %0d) expected 1", obs_q.size(), timed_out);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_uop%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        $display("test_reset_mid_expansion: fresh %0d micro-ops", obs_q.size());
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_arg1 = '0;
        bus.in_arg2 = '0; bus.in_dest = '0; bus.out_ready = 1'b0;
        rdy_pat = 16'h1; rdy_len = 1;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_serial();
        test_stall();
        test_cond_and_small();
        test_max_amount();
        test_reset_mid_expansion();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
